restoring_divider: RTL
======================

Name: restoring_divider

Overview:
- Sequential unsigned integer divider; the inverse arithmetic counterpart to the team's carry-select adder datapath.
- Computes quotient and remainder by repeated shift-and-subtract, one quotient bit per clock, MSB first.
- Subtraction is done as a + ~b + 1. The borrow is taken from the carry out, so the subtract stage reuses the existing adder style.
- Sits behind a start/busy/done handshake and is used by lab datapaths that need divide/modulo.

Parameters:
- WIDTH, 4, operand width in bits for dividend, divisor, quotient and remainder (WIDTH >= 2).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- dividend  input  WIDTH  unsigned dividend; captured on an accepted start
- divisor  input  WIDTH  unsigned divisor; captured on an accepted start
- busy  output  1  high while an operation is in progress
- done  output  1  single-cycle pulse; results are valid
- quotient  output  WIDTH  unsigned quotient; held until the next accepted start
- remainder  output  WIDTH  unsigned remainder; held until the next accepted start
- div_by_zero  output  1  set with done when divisor == 0; held with the results

Behaviour:
- Clocking: single clock domain. Reset is synchronous and active-high, applied on the clk rising edge when rst=1. Reset has priority over all other activity.
- Reset values:
  - State = IDLE.
  - busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
  - Internal iteration counter = 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 is accepted. On that edge, capture divisor D, load Q=dividend, R=0, count=0, div_by_zero=0.
  - If D != 0, go to RUN and set busy=1.
  - If D == 0, go to DONE directly with quotient={WIDTH{1}}, remainder=dividend, div_by_zero=1. busy stays 0.
  - start=0: remain in IDLE; outputs hold.
- RUN, one iteration per edge:
  - Form shifted remainder S = {R[WIDTH-2:0], Q[WIDTH-1]}. Compute T = S + ~D + 1 in WIDTH+1 bits.
  - carry out = 1 means no borrow: R<=T[WIDTH-1:0] and Q<={Q[WIDTH-2:0],1}.
  - carry out = 0 means borrow: R<=S and Q<={Q[WIDTH-2:0],0}.
  - Because R < D is an invariant, the true shifted remainder fits in WIDTH+1 bits. The implementation keeps R as WIDTH+1 bits internally so that S never truncates.
  - count increments each iteration. On the edge performing iteration WIDTH, go to DONE and set busy=0.
- DONE:
  - Lasts exactly one cycle with done=1.
  - quotient/remainder/div_by_zero outputs are driven from the final Q/R.
  - Next edge returns to IDLE, done=0; results hold.
  - start is ignored in DONE.
- Latency: start accepted at edge 0 → done high in the cycle after edge WIDTH (WIDTH cycles). For divide-by-zero, done is high in the cycle after edge 0.
- start while busy or in DONE: ignored, with no effect on operands or results.
- Back-to-back: start asserted in the first IDLE cycle after DONE is accepted. Throughput is one op per WIDTH+2 cycles.
- Operand inputs are don't-care except on the accepting edge; changes during RUN must not affect the result.
- Reset mid-operation: an rst=1 edge during RUN or DONE aborts immediately to IDLE with all outputs zero. No done pulse is produced for the aborted op.
- Result identity when div_by_zero=0: dividend == quotient*divisor + remainder and remainder < divisor, for all 2^(2*WIDTH) operand pairs.

Test Plan:
- WIDTH=4, reset, start with 13/3 → busy=1 for 4 cycles; done pulse in cycle 4; quotient=4, remainder=1, div_by_zero=0; outputs held after done drops.
- Boundary cases each run to done: 15/1 → q=15,r=0; 0/5 → q=0,r=0; 5/7 → q=0,r=5; 15/15 → q=1,r=0.
- 7/0 → done in cycle 1 with busy never high; quotient=4'hF, remainder=7, div_by_zero=1. A following 9/2 → q=4, r=1 and div_by_zero cleared.
- Start 12/5, then pulse start with 3/1 and toggle dividend/divisor during RUN and the DONE cycle → result still q=2,r=2 with a single done pulse; the second start is ignored.
- Start 14/3, assert rst on the second RUN cycle → next cycle busy=0, done=0, q=0, r=0, state IDLE. A subsequent 14/3 completes with q=4, r=2.
- Exhaustive sweep of all 256 operand pairs back-to-back (start in the first IDLE after each done) → every result checked against reference / and %; divisor 0 checked against the div_by_zero rule.

Source files
------------

// File: rtl/restoring_divider.sv
// rtl/restoring_divider.sv - sequential unsigned restoring divider, one quotient bit per clock
module restoring_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic             dbz_q, dbz_d;

  // Shifted partial remainder and its trial subtraction a + ~b + 1; the top sum bit is the carry.
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             no_borrow;
  // Top remainder bit only holds headroom for the shift; it is always zero between steps.
  logic             unused_r_msb;

  assign shifted      = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
  assign trial        = {1'b0, shifted} + {1'b0, ~{1'b0, div_q}} + {{(WIDTH+1){1'b0}}, 1'b1};
  assign no_borrow    = trial[WIDTH+1];
  assign unused_r_msb = r_q[WIDTH];

  // Next-state and datapath update for the IDLE / RUN / DONE sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    div_d   = div_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          div_d = divisor;
          cnt_d = '0;
          if (divisor != '0) begin
            q_d     = dividend;
            r_d     = '0;
            dbz_d   = 1'b0;
            state_d = S_RUN;
          end else begin
            q_d     = '1;
            r_d     = {1'b0, dividend};
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (no_borrow) begin
          r_d = trial[WIDTH:0];
          q_d = {q_q[WIDTH-2:0], 1'b1};
        end else begin
          r_d = shifted;
          q_d = {q_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything and aborts any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      div_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      div_q   <= div_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == S_RUN);
  assign done        = (state_q == S_DONE);
  assign quotient    = q_q;
  assign remainder   = r_q[WIDTH-1:0];
  assign div_by_zero = dbz_q;

endmodule
